// File: rtl/serial_pkg.sv
// serial_pkg -- shared definitions for the serial link blocks.
//   serial_state_t : frame controller states, used by both the piso
//                    transmitter and sipo-side controllers.
//   cnt_width()    : bit-counter width for a given word width.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serial_state_t;

  // Bit counter must index 0..w-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sipo.sv
// sipo -- serial-in parallel-out receiver, LSB first.
//   clk, reset   : clock, async active-high reset
//   enable       : bit strobe; a bit is taken on edges where enable=1
//   data_in      : serial data
//   bit_valid    : data_in carries a frame bit
//   word_valid   : one-cycle pulse when a full word has been assembled
//   word         : assembled word, valid while word_valid=1
module sipo
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  data_in,
  input  logic                  bit_valid,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] sreg_nxt;

  // LSB first: each new bit enters at the top and walks down.
  assign sreg_nxt = {data_in, sreg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (enable && bit_valid) begin
        sreg <= sreg_nxt;
        if (cnt == LAST) begin
          cnt        <= '0;
          word       <= sreg_nxt;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in serial-out transmitter, LSB first.
//   clk, reset  : clock, async active-high reset
//   enable      : bit strobe; the line advances only on edges with enable=1
//   load_valid  : load_data offered
//   load_data   : word to serialize
//   load_ready  : word is taken on this edge if load_valid=1
//   data_out    : serial bit (IDLE_LEVEL outside a frame)
//   bit_valid   : data_out carries a frame bit
//   busy        : frame in progress or a word is held
//   frame_done  : one-cycle pulse after the last bit of a word is consumed
// A one-entry hold buffer lets the next word queue up during a frame so
// consecutive words stream with no idle bit between them.
module piso_tx
  import serial_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  data_out,
  output logic                  bit_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  serial_state_t         state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [CNT_W-1:0]      cnt;
  logic                  accept;

  assign load_ready = !hold_full;
  assign accept     = load_valid && load_ready;
  assign bit_valid  = (state == SHIFT);
  assign data_out   = (state == SHIFT) ? shreg[0] : IDLE_LEVEL;
  assign busy       = (state == SHIFT) || hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // hold is always empty here: SHIFT only exits with hold drained.
          if (accept) begin
            shreg <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable && (cnt == LAST)) begin
            frame_done <= 1'b1;
            if (hold_full) begin
              // accept cannot fire here since load_ready=0
              shreg     <= hold;
              hold_full <= 1'b0;
              cnt       <= '0;
            end else if (accept) begin
              // word offered on the last-bit edge bypasses hold
              shreg <= load_data;
              cnt   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (enable) begin
              shreg <= shreg >> 1;
              cnt   <= cnt + CNT_W'(1);
            end
            // accepts continue while the line is frozen
            if (accept) begin
              hold      <= load_data;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- piso_tx with a sipo in loopback, checked every cycle
// against a word-queue model of the transmitter.
module tb_piso_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, data_out, bit_valid, busy, frame_done;
  logic         word_valid;
  logic [W-1:0] word;

  int n_cmp = 0;
  int n_err = 0;

  // model: words in flight (front is on the line), bit position in front word
  logic [W-1:0] pending[$];
  int           pos = 0;
  logic         exp_fd = 1'b0;
  logic         exp_wv = 1'b0;
  logic [W-1:0] exp_word = '0;

  always #5 clk = ~clk;

  piso_tx #(.DATA_WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .data_out(data_out),
    .bit_valid(bit_valid), .busy(busy), .frame_done(frame_done)
  );

  sipo #(.DATA_WIDTH(W)) rx (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_out),
    .bit_valid(bit_valid), .word_valid(word_valid), .word(word)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_outputs();
    logic [W-1:0] cur;
    logic         e_dout;
    e_dout = 1'b0;
    if (pending.size() > 0) begin
      cur    = pending[0];
      e_dout = cur[pos];
    end
    chk("data_out",   {31'd0, data_out},   {31'd0, e_dout});
    chk("bit_valid",  {31'd0, bit_valid},  {31'd0, pending.size() > 0});
    chk("load_ready", {31'd0, load_ready}, {31'd0, pending.size() < 2});
    chk("busy",       {31'd0, busy},       {31'd0, pending.size() > 0});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    chk("sipo_valid", {31'd0, word_valid}, {31'd0, exp_wv});
    if (exp_wv) chk("sipo_word", {24'd0, word}, {24'd0, exp_word});
  endtask

  task automatic model_edge();
    logic done, acc;
    done   = (pending.size() > 0) && enable && (pos == W - 1);
    acc    = load_valid && (pending.size() < 2);
    exp_fd = done;
    exp_wv = done;
    if (done) begin
      exp_word = pending.pop_front();
      pos      = 0;
    end else if (pending.size() > 0 && enable) begin
      pos++;
    end
    if (acc) pending.push_back(load_data);
  endtask

  // one clock: drive and check at negedge, advance the model at posedge
  task automatic step(input logic en, input logic lv, input logic [W-1:0] ld);
    @(negedge clk);
    enable     = en;
    load_valid = lv;
    load_data  = ld;
    chk_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    enable     = 1'b0;
    load_valid = 1'b0;
    #1;
    pending.delete();
    pos    = 0;
    exp_fd = 1'b0;
    exp_wv = 1'b0;
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_bit_valid",  {31'd0, bit_valid},  32'd0);
    chk("rst_data_out",   {31'd0, data_out},   32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_sipo_valid", {31'd0, word_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // power-on reset
    repeat (2) @(posedge clk);
    do_reset();

    // single word, enable always high
    step(1'b1, 1'b1, 8'hA5);
    idle(10);

    // second word offered mid-frame goes to hold and follows with no gap
    step(1'b1, 1'b1, 8'h3C);
    idle(2);
    step(1'b1, 1'b1, 8'hC3);
    idle(3);
    step(1'b1, 1'b1, 8'h77);  // refused: hold is full
    idle(16);

    // enable high one cycle in three
    for (int i = 0; i < 30; i++) step(i % 3 == 0, i == 0, 8'h5A);
    idle(3);

    // reset mid-frame with a word held
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'h0F);
    idle(3);
    do_reset();
    step(1'b1, 1'b1, 8'h81);
    idle(10);

    // word offered exactly on the last-bit edge bypasses hold
    step(1'b1, 1'b1, 8'h11);
    idle(7);
    step(1'b1, 1'b1, 8'h96);
    idle(10);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, W'($urandom));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
